data_main_memory: RTL and testbench
===================================

Name: data_main_memory

Overview:
- Block-granular main memory. It is the responder on the cache-to-main-memory interface: it serves 128-bit block reads and writes that the data cache initiates.
- It models a fixed multi-cycle access latency and uses a busywait handshake that the cache controller stalls on.
- It sits below data_cache_memory in the data memory module and has no other bus masters.

Parameters:
- ADDR_BITS, 8, number of block-index bits actually decoded; depth is 2^ADDR_BITS blocks of 128 bits.
- LATENCY, 5, cycles spent in BUSY per access; legal range 1 to 255.

Ports:
- clock  input  1  single system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- read  input  1  block read request; held by the initiator until busywait is seen low.
- write  input  1  block write request; same hold rule as read.
- address  input  28  block address ({tag, index} from the cache); only address[ADDR_BITS-1:0] is decoded.
- writedata  input  128  block to write; sampled at request acceptance.
- readdata  output  128  block read result; registered.
- busywait  output  1  high while a request is pending or in progress.
- protocol_error  output  1  sticky flag; set when read and write are both high at acceptance.

Behaviour:
- Reset is asynchronous and active-high. On assertion:
  - state goes to IDLE;
  - busywait, readdata and protocol_error go to 0;
  - the latched request and any pending write are discarded and the array is not written.
- Array contents are not affected by reset. The array is zero-initialised at simulation start.
- States are IDLE, BUSY and DONE.
- IDLE:
  - busywait = read | write, combinationally in the same cycle. This is mandatory: the initiator treats busywait low while it is requesting as completion.
  - On a posedge with read or write high:
    - latch address[ADDR_BITS-1:0], writedata and the operation type;
    - load the counter with LATENCY-1;
    - go to BUSY.
  - If read and write are both high, write takes priority and protocol_error is set to 1. protocol_error clears only on reset.
- BUSY:
  - busywait = 1.
  - Each posedge with counter != 0 decrements the counter.
  - On the posedge with counter == 0:
    - write: data_array[latched index] <= latched writedata;
    - read: readdata <= data_array[latched index];
    - go to DONE.
- DONE:
  - busywait = 0 for exactly one cycle. readdata holds the completed block during this cycle.
  - The next posedge returns to IDLE unconditionally. A request that is still asserted at this edge is NOT accepted; it is evaluated fresh in IDLE on the following cycle.
- Timing: busywait is high for LATENCY+1 cycles (the request cycle plus LATENCY BUSY cycles), then low for 1 DONE cycle.
- Input changes during BUSY or DONE are ignored; the latched values are used.
- readdata holds its value until the next read completes. Write accesses do not change readdata.
- Address wrap: upper address bits [27:ADDR_BITS] are ignored, so an address of 2^ADDR_BITS aliases block 0.
- A read of a block written earlier returns the written value. This includes a read issued in the IDLE cycle immediately after a write's DONE, which covers the back-to-back write-back then refill sequence of a dirty miss.
- Reset asserted during BUSY: the access is aborted and the array is unchanged.
- Reset asserted during DONE of a write: the array was already updated at the preceding edge and keeps the written value.

Test Plan:
- Reset, then read=1 at address 0x0000003 (LATENCY=5) -> busywait rises the same cycle and stays high 6 cycles, then is low for 1 cycle; readdata = 0 in the DONE cycle.
- Write 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D to address 0x0000010, then read address 0x0000010 -> readdata equals that value in the read's DONE cycle. Total 14 cycles including both DONE cycles and the intervening IDLE cycle.
- Back-to-back: write to block 0x05 with read asserted the cycle after DONE -> the read is accepted, busywait rises combinationally, and the second read returns the new data.
- Wrap: write 0x...AA to address 0x0000100 (ADDR_BITS=8), then read address 0x0000000 -> readdata = 0x...AA.
- Reset pulsed at the 3rd BUSY cycle of a write of 0x...55 to block 0x07 -> busywait drops to 0 immediately; a later read of 0x07 returns the previous contents, not 0x...55.
- read=1 and write=1 together at acceptance -> the write is performed and protocol_error = 1, and protocol_error stays 1 through later accesses until reset.

Source files
------------

// File: rtl/data_main_memory.sv
// Block-granular main memory behind the data cache: 128-bit block reads and writes
// with a fixed access latency and a busywait handshake the cache controller stalls on.
module data_main_memory #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic         write,
    input  logic [27:0]  address,
    input  logic [127:0] writedata,
    output logic [127:0] readdata,
    output logic         busywait,
    output logic         protocol_error
);

    localparam int unsigned Depth = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic [127:0]         wdata_q, wdata_d;
    logic                 is_write_q, is_write_d;
    logic [127:0]         readdata_q, readdata_d;
    logic                 perr_q, perr_d;
    logic                 mem_we;

    // Contents survive reset; only the power-on value is defined.
    logic [127:0] mem_q [Depth] = '{default: '0};

    // Upper block-address bits alias onto the decoded range.
    logic unused_addr;
    assign unused_addr = ^address[27:ADDR_BITS];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        readdata_d = readdata_q;
        perr_d     = perr_q;
        busywait   = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Must rise in the request cycle: a low busywait reads as completion.
                busywait = (read | write) & ~reset;
                if (read | write) begin
                    idx_d      = address[ADDR_BITS-1:0];
                    wdata_d    = writedata;
                    is_write_d = write;
                    cnt_d      = 8'(LATENCY - 1);
                    state_d    = StBusy;
                    if (read && write) begin
                        perr_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                busywait = 1'b1;
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    if (is_write_q) begin
                        mem_we = 1'b1;
                    end else begin
                        readdata_d = mem_q[idx_q];
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            idx_q      <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            readdata_q <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            readdata_q <= readdata_d;
            perr_q     <= perr_d;
        end
    end

    // mem_we is only raised from StBusy, so an aborted access never lands.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign readdata       = readdata_q;
    assign protocol_error = perr_q;

endmodule

// File: tb/tb_data_main_memory.sv
// Self-checking bench for data_main_memory: directed vector table, hand-written
// reset/handshake sequences, and random accesses against an array reference model.
module tb_data_main_memory;

    localparam int unsigned AB  = 8;
    localparam int unsigned LAT = 5;

    localparam logic [127:0] KA = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] KB = 128'h05050505_11112222_33334444_5555AAAA;
    localparam logic [127:0] AA = {16{8'hAA}};
    localparam logic [127:0] K2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] K3 = 128'hBAD0_BAD1_BAD2_BAD3_BAD4_BAD5_BAD6_BAD7;
    localparam logic [127:0] K4 = 128'h7777_0000_7777_0000_7777_0000_7777_0000;
    localparam logic [127:0] K5 = 128'h9999_8888_7777_6666_5555_4444_3333_2222;
    localparam logic [127:0] F5 = {16{8'h55}};

    logic         clock;
    logic         reset;
    logic         read;
    logic         write;
    logic [27:0]  address;
    logic [127:0] writedata;
    logic [127:0] readdata;
    logic         busywait;
    logic         protocol_error;

    data_main_memory #(
        .ADDR_BITS(AB),
        .LATENCY  (LAT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .protocol_error(protocol_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] ref_mem [1 << AB];
    logic [127:0] ref_rd;
    logic         ref_perr;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wd;
        logic [127:0] exp_rd;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic model_apply(input logic rd, input logic wr, input logic [27:0] a,
                               input logic [127:0] wd);
        if (wr) ref_mem[a[AB-1:0]] = wd;
        else if (rd) ref_rd = ref_mem[a[AB-1:0]];
        if (rd && wr) ref_perr = 1'b1;
    endtask

    // Entered and left 1 time unit after a posedge in an idle cycle.
    task automatic access(input logic rd, input logic wr, input logic [27:0] a,
                          input logic [127:0] wd, output logic [127:0] rdata,
                          output int hi_cycles);
        read      = rd;
        write     = wr;
        address   = a;
        writedata = wd;
        hi_cycles = 0;
        #1;
        while (busywait && hi_cycles < 300) begin
            hi_cycles++;
            @(posedge clock);
            #2;
        end
        rdata = readdata;
        read  = 1'b0;
        write = 1'b0;
        @(posedge clock);
        #1;
    endtask

    logic [127:0] rdata;
    int           hi;
    int           steps;
    logic         rd_r, wr_r;
    logic [27:0]  a_r;
    logic [127:0] wd_r;
    int unsigned  r;

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = '0;
        ref_rd   = '0;
        ref_perr = 1'b0;

        tbl[0] = '{1'b1, 1'b0, 28'h0000003, 128'h0, 128'h0};
        tbl[1] = '{1'b0, 1'b1, 28'h0000010, KA,     128'h0};
        tbl[2] = '{1'b1, 1'b0, 28'h0000010, 128'h0, KA};
        tbl[3] = '{1'b0, 1'b1, 28'h0000005, KB,     KA};
        tbl[4] = '{1'b1, 1'b0, 28'h0000005, 128'h0, KB};
        tbl[5] = '{1'b0, 1'b1, 28'h0000100, AA,     KB};
        tbl[6] = '{1'b1, 1'b0, 28'h0000000, 128'h0, AA};
        tbl[7] = '{1'b1, 1'b0, 28'h0000100, 128'h0, AA};
        tbl[8] = '{1'b0, 1'b1, 28'hFF000A3, K2,     AA};
        tbl[9] = '{1'b1, 1'b0, 28'h00000A3, 128'h0, K2};

        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        #12;
        check("reset_busywait", 128'(busywait), 128'(0));
        check("reset_readdata", readdata, 128'h0);
        check("reset_perr", 128'(protocol_error), 128'(0));
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Directed table; each access must also hold busywait for LAT+1 cycles.
        for (int i = 0; i < 10; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, rdata, hi);
            model_apply(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd);
            check($sformatf("tbl%0d_readdata", i), rdata, tbl[i].exp_rd);
            check($sformatf("tbl%0d_busy_cycles", i), 128'(hi), 128'(LAT + 1));
            check($sformatf("tbl%0d_perr", i), 128'(protocol_error), 128'(0));
        end

        // Simultaneous read+write: write wins, error flag sticks.
        access(1'b1, 1'b1, 28'h0000020, K3, rdata, hi);
        model_apply(1'b1, 1'b1, 28'h0000020, K3);
        check("both_perr", 128'(protocol_error), 128'(1));
        check("both_readdata_kept", rdata, K2);
        access(1'b1, 1'b0, 28'h0000020, '0, rdata, hi);
        model_apply(1'b1, 1'b0, 28'h0000020, '0);
        check("both_write_done", rdata, K3);
        check("both_perr_sticky", 128'(protocol_error), 128'(1));

        // Reset during the third BUSY cycle of a write aborts it.
        access(1'b0, 1'b1, 28'h0000007, K4, rdata, hi);
        model_apply(1'b0, 1'b1, 28'h0000007, K4);
        write = 1'b1; address = 28'h0000007; writedata = F5;
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busywait", 128'(busywait), 128'(0));
        check("abort_readdata", readdata, 128'h0);
        check("abort_perr_cleared", 128'(protocol_error), 128'(0));
        write = 1'b0;
        ref_rd = '0;
        ref_perr = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        access(1'b1, 1'b0, 28'h0000007, '0, rdata, hi);
        model_apply(1'b1, 1'b0, 28'h0000007, '0);
        check("abort_old_contents", rdata, K4);

        // Reset during DONE of a write keeps the written block.
        write = 1'b1; address = 28'h0000009; writedata = K5;
        steps = 0;
        #1;
        while (busywait && steps < 300) begin
            steps++;
            @(posedge clock);
            #2;
        end
        check("done_reset_cycles", 128'(steps), 128'(LAT + 1));
        reset = 1'b1;
        #1;
        write = 1'b0;
        ref_mem[9] = K5;
        ref_rd = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        access(1'b1, 1'b0, 28'h0000009, '0, rdata, hi);
        model_apply(1'b1, 1'b0, 28'h0000009, '0);
        check("done_reset_kept", rdata, K5);

        // Held read: DONE is a single low cycle and never accepts the held request.
        read = 1'b1; address = 28'h0000009;
        for (int i = 0; i < 14; i++) begin
            #1;
            check($sformatf("held_bw_%0d", i), 128'(busywait), 128'((i % 7) != 6));
            if (i == 6) check("held_done_data", readdata, K5);
            @(posedge clock);
            #1;
        end
        read = 1'b0;
        @(posedge clock);
        #1;

        // Random accesses against the reference model.
        for (int i = 0; i < 40; i++) begin
            r    = $urandom_range(0, 9);
            rd_r = (r < 5) || (r == 9);
            wr_r = (r >= 5);
            a_r  = 28'($urandom);
            a_r[AB-1:0] = 8'($urandom_range(0, 15));
            wd_r = {$urandom, $urandom, $urandom, $urandom};
            access(rd_r, wr_r, a_r, wd_r, rdata, hi);
            model_apply(rd_r, wr_r, a_r, wd_r);
            check($sformatf("rnd%0d_readdata", i), rdata, ref_rd);
            check($sformatf("rnd%0d_busy_cycles", i), 128'(hi), 128'(LAT + 1));
            check($sformatf("rnd%0d_perr", i), 128'(protocol_error), 128'(ref_perr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
